arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester.sv | 161 ++++++++++++++++
 tb/tb_arb_requester.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: request FIFO that feeds one arbiter port.
// Entries are {payload, priority} pairs. The head entry is presented to the
// arbiter as req/pri. The priority of a waiting request ages upward, and a
// grant issues the payload as a one-cycle out_valid pulse.
//
// Handshake: req is held high in REQ until gnt is seen high at a rising edge.
// The following cycle is XFER, where req=0 and out_valid=1. The head entry is
// popped at the end of XFER. Because of this, req is always low for at least
// one cycle between grants, and gnt is ignored whenever req is low.
//
// fsm_state is a debug view of the FSM (0=IDLE, 1=REQ, 2=XFER).
module arb_requester #(
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter int PW        = 3,
  parameter int AGE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [PW-1:0] wr_pri,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          req,
  output logic [PW-1:0] pri,
  input  logic          gnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] AGE_LAST   = CW'(AGE_LIMIT - 1);
  localparam logic [PW-1:0] PRI_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t        st;
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] mem_pri  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [CW-1:0] wait_cnt;
  logic          wr_accept;
  logic          pop;
  logic [PW-1:0] next_head_pri;

  assign fsm_state = st;

  // Compute the FIFO next-state terms and the priority of the entry that follows the head
  always_comb begin
    wr_accept   = wr_en && !full;
    pop         = (st == S_XFER) && !empty;
    rd_ptr_next = rd_ptr + 1'b1;
    count_next  = count;
    if (wr_accept && !pop) begin
      count_next = count + COUNT_ONE;
    end else if (!wr_accept && pop) begin
      count_next = count - COUNT_ONE;
    end
    // If the head is the last entry, a write in the same cycle becomes the new head
    next_head_pri = (count > COUNT_ONE) ? mem_pri[rd_ptr_next] : wr_pri;
  end

  // Storage array, written at the write pointer when a push is accepted
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_data[wr_ptr] <= wr_data;
      mem_pri[wr_ptr]  <= wr_pri;
    end
  end

  // Pointers, occupancy, registered full/empty flags and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr_next;
      if (wr_en && full) ovf <= 1'b1;
      count <= count_next;
      full  <= (count_next == COUNT_FULL);
      empty <= (count_next == '0);
    end
  end

  // Request FSM: load priority, age it while waiting, issue payload on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      req       <= 1'b0;
      pri       <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (!empty) begin
            st       <= S_REQ;
            req      <= 1'b1;
            pri      <= mem_pri[rd_ptr];
            wait_cnt <= '0;
          end else begin
            req <= 1'b0;
          end
        end
        S_REQ: begin
          if (gnt) begin
            st        <= S_XFER;
            req       <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= mem_data[rd_ptr];
            wait_cnt  <= '0;
          end else if (wait_cnt == AGE_LAST) begin
            wait_cnt <= '0;
            if (pri != PRI_MAX) pri <= pri + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_XFER: begin
          out_valid <= 1'b0;
          if (count_next != '0) begin
            st       <= S_REQ;
            req      <= 1'b1;
            pri      <= next_head_pri;
            wait_cnt <= '0;
          end else begin
            st  <= S_IDLE;
            req <= 1'b0;
          end
        end
        default: begin
          st        <= S_IDLE;
          req       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed testbench for arb_requester. Inputs are driven, and outputs are
// sampled, 1 time unit after each rising edge. Expected values are worked
// out by hand from the intended behaviour.
module tb_arb_requester;

  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [PW-1:0] wr_pri;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          req;
  logic [PW-1:0] pri;
  logic          gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    fsm_state;

  int n_cmp;
  int n_err;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  arb_requester #(.DEPTH(4), .DW(DW), .PW(PW), .AGE_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_pri    (wr_pri),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .req       (req),
    .pri       (pri),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [PW-1:0] p);
    wr_en   = 1'b1;
    wr_data = d;
    wr_pri  = p;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_pri;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_pri  = '0;
    gnt     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_pri", 32'(pri), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // gnt while idle and empty has no effect
    gnt = 1'b1;
    step();
    step();
    chk("idle_gnt_out_valid", 32'(out_valid), 32'd0);
    chk("idle_gnt_empty", 32'(empty), 32'd1);
    chk("idle_gnt_state", 32'(fsm_state), 32'(ST_IDLE));
    gnt = 1'b0;

    // Single push 0xA5 pri 2; grant two cycles after req rises
    push(8'hA5, 3'd2);
    chk("single_empty_after_wr", 32'(empty), 32'd0);
    chk("single_req_first_edge", 32'(req), 32'd0);
    step();
    chk("single_req", 32'(req), 32'd1);
    chk("single_pri", 32'(pri), 32'd2);
    chk("single_state_req", 32'(fsm_state), 32'(ST_REQ));
    step();
    chk("single_req_hold", 32'(req), 32'd1);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_req_xfer", 32'(req), 32'd0);
    chk("single_state_xfer", 32'(fsm_state), 32'(ST_XFER));
    step();
    chk("single_out_valid_drop", 32'(out_valid), 32'd0);
    chk("single_out_data_hold", 32'(out_data), 32'hA5);
    chk("single_empty_end", 32'(empty), 32'd1);
    chk("single_state_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Aging: pri 5 steps every 8 waiting cycles and saturates at 7
    push(8'h37, 3'd5);
    step();
    chk("age_req", 32'(req), 32'd1);
    chk("age_pri_start", 32'(pri), 32'd5);
    for (int i = 1; i <= 24; i++) begin
      step();
      exp_pri = 5 + i / 8;
      if (exp_pri > 7) exp_pri = 7;
      chk($sformatf("age_pri_%0d", i), 32'(pri), 32'(exp_pri));
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("age_out_data", 32'(out_data), 32'h37);
    step();
    chk("age_state_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Fill to full, overflow attempt, then drain with gnt held high
    push(8'h01, 3'd1);
    push(8'h02, 3'd1);
    push(8'h03, 3'd1);
    chk("fill_full_3", 32'(full), 32'd0);
    push(8'h04, 3'd1);
    chk("fill_full_4", 32'(full), 32'd1);
    chk("fill_ovf_clear", 32'(ovf), 32'd0);
    push(8'h05, 3'd1);
    chk("fill_ovf_set", 32'(ovf), 32'd1);
    chk("fill_full_hold", 32'(full), 32'd1);
    gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) begin
        chk($sformatf("drain_out_valid_%0d", k), 32'(out_valid), 32'd1);
        chk($sformatf("drain_out_data_%0d", k), 32'(out_data), 32'(k / 2 + 1));
        chk($sformatf("drain_req_%0d", k), 32'(req), 32'd0);
      end else begin
        chk($sformatf("drain_out_valid_%0d", k), 32'(out_valid), 32'd0);
        chk($sformatf("drain_req_%0d", k), 32'(req), (k == 7) ? 32'd0 : 32'd1);
      end
      if (k == 1) chk("drain_full_clear", 32'(full), 32'd0);
    end
    gnt = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(ovf), 32'd1);
    chk("drain_state_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Push and pop in the same cycle at count 2
    push(8'h11, 3'd3);
    push(8'h22, 3'd4);
    chk("pp_state_req", 32'(fsm_state), 32'(ST_REQ));
    chk("pp_pri_head", 32'(pri), 32'd3);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("pp_out_11", 32'(out_data), 32'h11);
    push(8'h33, 3'd6);
    chk("pp_req_after_pop", 32'(req), 32'd1);
    chk("pp_pri_next", 32'(pri), 32'd4);
    chk("pp_full", 32'(full), 32'd0);
    gnt = 1'b1;
    step();
    chk("pp_out_22", 32'(out_data), 32'h22);
    chk("pp_out_valid_22", 32'(out_valid), 32'd1);
    step();
    chk("pp_pri_last", 32'(pri), 32'd6);
    chk("pp_empty_mid", 32'(empty), 32'd0);
    step();
    gnt = 1'b0;
    chk("pp_out_33", 32'(out_data), 32'h33);
    step();
    chk("pp_empty_end", 32'(empty), 32'd1);
    chk("pp_state_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Asynchronous reset while requesting with three entries queued
    push(8'h41, 3'd1);
    push(8'h42, 3'd1);
    push(8'h43, 3'd1);
    chk("mr_req_before", 32'(req), 32'd1);
    gnt   = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(req), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_ovf", 32'(ovf), 32'd0);
    chk("mr_state", 32'(fsm_state), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("mr_out_valid_%0d", j), 32'(out_valid), 32'd0);
      chk($sformatf("mr_empty_%0d", j), 32'(empty), 32'd1);
    end
    gnt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
